stream_downscaler: RTL and testbench

- Streaming nearest-neighbour image downscaler for the Viola-Jones pyramid.
- Consumes one raster-order frame of SRC_W x SRC_H pixels through a valid/ready handshake.
- Emits the DST_W x DST_H subsampled frame in raster order.
- Sequential successor of the combinational full-frame downscaler: one pixel per cycle, parametrised sizes, non-integer ratios, frame framing, and backpressure.

---
 rtl/vj_stream_pkg.sv | 25 ++
 rtl/downscale_axis_counter.sv | 69 ++++++
 rtl/stream_downscaler.sv | 141 ++++++++++++++
 tb/tb_stream_downscaler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vj_stream_pkg.sv
// ---------------------------------------------------------------------------
// vj_stream_pkg : shared types and helpers for the Viola-Jones stream blocks
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package vj_stream_pkg;

    localparam int DEFAULT_PIX_W = 32;

    typedef logic [DEFAULT_PIX_W-1:0] pix_t;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Accumulator width: integer part wide enough to hold the source size.
    function automatic int step_width(input int src, input int frac_w);
        return $clog2(src) + frac_w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/downscale_axis_counter.sv
// ---------------------------------------------------------------------------
// downscale_axis_counter : per-axis source position, step accumulator and
// destination index for the nearest-neighbour downscaler
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module downscale_axis_counter
    import vj_stream_pkg::*;
#(
    parameter int SRC    = 160,
    parameter int DST    = 133,
    parameter int FRAC_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       restart,
    input  logic                       advance,
    output logic                       keep,
    output logic                       wrap,
    output logic [$clog2(DST+1)-1:0]   dst_idx
);

    localparam int CW = (SRC > 1) ? $clog2(SRC) : 1;
    localparam int DW = $clog2(DST + 1);
    localparam int AW = step_width(SRC, FRAC_W);
    localparam int IW = AW - FRAC_W;
    localparam logic [AW-1:0] STEP = AW'((64'(SRC) << FRAC_W) / 64'(DST));

    logic [CW-1:0] src_pos, cur_src;
    logic [AW-1:0] acc, cur_acc;
    logic [DW-1:0] dst_pos, cur_dst;

    // A restart makes the current beat position zero before it is evaluated.
    always_comb begin
        cur_src = restart ? '0 : src_pos;
        cur_acc = restart ? '0 : acc;
        cur_dst = restart ? '0 : dst_pos;
        wrap    = (cur_src == CW'(SRC - 1));
        // dst guard stops truncated steps from sampling one extra position
        keep    = (IW'(cur_src) == cur_acc[AW-1:FRAC_W]) && (cur_dst < DW'(DST));
        dst_idx = cur_dst;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            src_pos <= '0;
            acc     <= '0;
            dst_pos <= '0;
        end else if (advance) begin
            if (wrap) begin
                src_pos <= '0;
                acc     <= '0;
                dst_pos <= '0;
            end else begin
                src_pos <= cur_src + CW'(1);
                acc     <= keep ? cur_acc + STEP : cur_acc;
                dst_pos <= keep ? cur_dst + DW'(1) : cur_dst;
            end
        end else if (restart) begin
            src_pos <= '0;
            acc     <= '0;
            dst_pos <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_downscaler.sv
// ---------------------------------------------------------------------------
// stream_downscaler : streaming nearest-neighbour frame downscaler with
// valid/ready handshake and frame framing
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module stream_downscaler
    import vj_stream_pkg::*;
#(
    parameter int PIX_W  = DEFAULT_PIX_W,
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int DST_W  = 133,
    parameter int DST_H  = 100,
    parameter int FRAC_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_eol,
    output logic             out_eof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             sof_error
);

    localparam int CDW = $clog2(DST_W + 1);
    localparam int RDW = $clog2(DST_H + 1);

    state_t         state, state_next;
    logic           in_beat, process, restart, kept, sof_err_next;
    logic           h_keep, h_wrap, v_keep, v_wrap;
    logic [CDW-1:0] dst_col;
    logic [RDW-1:0] dst_row;
    logic           kept_eol;

    assign in_ready   = !reset && (!out_valid || out_ready);
    assign in_beat    = in_valid && in_ready;
    assign frame_done = !reset && out_valid && out_ready && out_eof;
    assign kept       = process && h_keep && v_keep;
    assign kept_eol   = (dst_col == CDW'(DST_W - 1));

    downscale_axis_counter #(
        .SRC    (SRC_W),
        .DST    (DST_W),
        .FRAC_W (FRAC_W)
    ) u_h_cnt (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .advance (process),
        .keep    (h_keep),
        .wrap    (h_wrap),
        .dst_idx (dst_col)
    );

    // The vertical axis advances once per completed source row.
    downscale_axis_counter #(
        .SRC    (SRC_H),
        .DST    (DST_H),
        .FRAC_W (FRAC_W)
    ) u_v_cnt (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .advance (process && h_wrap),
        .keep    (v_keep),
        .wrap    (v_wrap),
        .dst_idx (dst_row)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        process      = 1'b0;
        restart      = 1'b0;
        sof_err_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_beat) begin
                    if (in_sof) begin
                        process    = 1'b1;
                        restart    = 1'b1;
                        state_next = S_ACTIVE;
                    end else begin
                        sof_err_next = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (in_beat) begin
                    process = 1'b1;
                    if (in_sof) begin
                        restart      = 1'b1;
                        sof_err_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (process && h_wrap && v_wrap) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            sof_error <= 1'b0;
        end else begin
            sof_error <= sof_err_next;
            if (kept) begin
                out_valid <= 1'b1;
                out_pix   <= in_pix;
                out_eol   <= kept_eol;
                out_eof   <= kept_eol && (dst_row == RDW'(DST_H - 1));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_downscaler.sv
// ---------------------------------------------------------------------------
// tb_stream_downscaler : directed self-checking bench for stream_downscaler
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_downscaler;
    import vj_stream_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic [31:0] a_in_pix, a_out_pix, b_in_pix, b_out_pix, c_in_pix, c_out_pix;
    logic a_in_sof, a_in_valid, a_in_ready, a_out_eol, a_out_eof, a_out_valid, a_out_ready;
    logic a_frame_done, a_sof_error;
    logic b_in_sof, b_in_valid, b_in_ready, b_out_eol, b_out_eof, b_out_valid, b_out_ready;
    logic b_frame_done, b_sof_error;
    logic c_in_sof, c_in_valid, c_in_ready, c_out_eol, c_out_eof, c_out_valid, c_out_ready;
    logic c_frame_done, c_sof_error;

    stream_downscaler #(.PIX_W(32), .SRC_W(8), .SRC_H(6), .DST_W(4), .DST_H(3), .FRAC_W(16)) dut_a (
        .clock(clock), .reset(reset), .in_pix(a_in_pix), .in_sof(a_in_sof), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_pix(a_out_pix), .out_eol(a_out_eol), .out_eof(a_out_eof),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .frame_done(a_frame_done),
        .sof_error(a_sof_error));

    stream_downscaler #(.PIX_W(32), .SRC_W(10), .SRC_H(1), .DST_W(4), .DST_H(1), .FRAC_W(16)) dut_b (
        .clock(clock), .reset(reset), .in_pix(b_in_pix), .in_sof(b_in_sof), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_pix(b_out_pix), .out_eol(b_out_eol), .out_eof(b_out_eof),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .frame_done(b_frame_done),
        .sof_error(b_sof_error));

    stream_downscaler #(.PIX_W(32), .SRC_W(160), .SRC_H(120), .DST_W(133), .DST_H(100), .FRAC_W(16)) dut_c (
        .clock(clock), .reset(reset), .in_pix(c_in_pix), .in_sof(c_in_sof), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_pix(c_out_pix), .out_eol(c_out_eol), .out_eof(c_out_eof),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .frame_done(c_frame_done),
        .sof_error(c_sof_error));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Random sink readiness for dut_a, updated just after each rising edge.
    bit rnd_mode = 1'b0;
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            a_out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [33:0] qa[$];
    logic [33:0] ea[$];
    logic [33:0] qb[$];
    int a_fd = 0, a_serr = 0, hold_err = 0, b_fd = 0;
    logic prev_stall = 1'b0;
    logic [33:0] prev_out = '0;

    always @(negedge clock) begin
        if (prev_stall && !reset && {a_out_valid, a_out_eol, a_out_eof, a_out_pix} !== {1'b1, prev_out})
            hold_err <= hold_err + 1;
        prev_stall <= a_out_valid && !a_out_ready;
        prev_out   <= {a_out_eol, a_out_eof, a_out_pix};
        if (a_out_valid && a_out_ready) qa.push_back({a_out_eol, a_out_eof, a_out_pix});
        if (a_frame_done) a_fd <= a_fd + 1;
        if (a_sof_error)  a_serr <= a_serr + 1;
        if (b_out_valid && b_out_ready) qb.push_back({b_out_eol, b_out_eof, b_out_pix});
        if (b_frame_done) b_fd <= b_fd + 1;
    end

    // Golden per-level model for the 160x120 -> 133x100 quadrant frame.
    function automatic logic [32:0] quad_exp(input int k);
        int r, c, sr, sc;
        r  = k / 133;
        c  = k % 133;
        sr = (r * 78643) >>> 16;
        sc = (c * 78840) >>> 16;
        return {c == 132, 32'((sr >= 60 ? 2 : 0) + (sc >= 80 ? 1 : 0))};
    endfunction

    int c_cnt = 0, c_bad = 0, c_eof = 0, c_eof_idx = -1, c_fd = 0;
    always @(negedge clock) begin
        if (c_out_valid && c_out_ready) begin
            if ({c_out_eol, c_out_pix} !== quad_exp(c_cnt)) c_bad <= c_bad + 1;
            if (c_out_eof) begin
                c_eof     <= c_eof + 1;
                c_eof_idx <= c_cnt;
            end
            c_cnt <= c_cnt + 1;
        end
        if (c_frame_done) c_fd <= c_fd + 1;
    end

    // Expected 4x3 outputs of an 8x6 frame whose first source beat has index off.
    task automatic add_frame(input int off);
        for (int k = 0; k < 12; k++) begin
            int j;
            j = off + (2 * (k / 4)) * 8 + 2 * (k % 4);
            ea.push_back({(k % 4) == 3, k == 11, 32'((j / 8) * 16 + j % 8)});
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic send_a(input int n, input int sof_at, input bit lat);
        for (int i = 0; i < n; i++) begin
            int tmo;
            bit acc;
            tmo = 0;
            acc = 1'b0;
            a_in_pix   = 32'((i / 8) * 16 + i % 8);
            a_in_sof   = (i == 0) || (i == sof_at);
            a_in_valid = 1'b1;
            while (!acc && tmo < 200) begin
                #2;
                if (lat && i == 1 && tmo == 0) begin
                    check("latency_valid", a_out_valid, 1);
                    check("latency_pix", a_out_pix, 0);
                end
                acc = a_in_ready;
                @(posedge clock);
                #1;
                tmo++;
            end
            if (!acc) begin
                check("send_accept", acc, 1);
                break;
            end
        end
        a_in_valid = 1'b0;
        a_in_sof   = 1'b0;
    endtask

    task automatic drain_a(input int n);
        int t;
        t = 0;
        while ((qa.size() < n || a_out_valid) && t < 300) begin
            @(posedge clock);
            #3;
            t++;
        end
        if (t >= 300) check("drain_timeout", 64'(t), 64'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic cmp_a(input string tag);
        check({tag, "_count"}, 64'(qa.size()), 64'(ea.size()));
        for (int k = 0; k < ea.size() && k < qa.size(); k++)
            check($sformatf("%s[%0d]", tag, k), qa[k], ea[k]);
        qa.delete();
        ea.delete();
    endtask

    initial begin
        int fd0, se0;
        reset = 1'b1;
        a_in_pix = '0; a_in_sof = 1'b0; a_in_valid = 1'b0;
        b_in_pix = '0; b_in_sof = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        c_in_pix = '0; c_in_sof = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #3;
        check("rst_in_ready", a_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_pix", a_out_pix, 0);
        check("rst_flags", {a_out_eol, a_out_eof, a_frame_done, a_sof_error}, 0);
        check("rst_state", dut_a.state, S_IDLE);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 8x6 -> 4x3, free-flowing sink
        add_frame(0);
        send_a(48, -1, 1'b1);
        drain_a(12);
        cmp_a("plain");
        check("plain_frame_done", 64'(a_fd), 64'(1));
        check("plain_sof_error", 64'(a_serr), 64'(0));

        // 10x1 -> 4x1, fractional step 2.5
        for (int i = 0; i < 10; i++) begin
            b_in_pix = 32'(i); b_in_sof = (i == 0); b_in_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        b_in_valid = 1'b0; b_in_sof = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("frac_count", 64'(qb.size()), 64'(4));
        if (qb.size() == 4) begin
            check("frac[0]", qb[0], {2'b00, 32'd0});
            check("frac[1]", qb[1], {2'b00, 32'd2});
            check("frac[2]", qb[2], {2'b00, 32'd5});
            check("frac[3]", qb[3], {2'b11, 32'd7});
        end
        check("frac_frame_done", 64'(b_fd), 64'(1));

        // 160x120 -> 133x100 quadrant frame
        for (int i = 0; i < 19200; i++) begin
            c_in_pix = 32'(((i / 160) >= 60 ? 2 : 0) + ((i % 160) >= 80 ? 1 : 0));
            c_in_sof = (i == 0); c_in_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        c_in_valid = 1'b0; c_in_sof = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("quad_count", 64'(c_cnt), 64'(13300));
        check("quad_mismatches", 64'(c_bad), 64'(0));
        check("quad_eof_count", 64'(c_eof), 64'(1));
        check("quad_eof_index", 64'(c_eof_idx), 64'(13299));
        check("quad_frame_done", 64'(c_fd), 64'(1));

        // Random 50% backpressure on the 8x6 frame
        fd0 = a_fd;
        rnd_mode = 1'b1;
        add_frame(0);
        send_a(48, -1, 1'b0);
        drain_a(12);
        rnd_mode = 1'b0;
        cmp_a("bp");
        check("bp_hold", 64'(hold_err), 64'(0));
        check("bp_frame_done", 64'(a_fd - fd0), 64'(1));

        // Unexpected in_sof at source beat 20, then a normal frame
        fd0 = a_fd;
        se0 = a_serr;
        ea.push_back({2'b00, 32'h00});
        ea.push_back({2'b00, 32'h02});
        ea.push_back({2'b00, 32'h04});
        ea.push_back({2'b10, 32'h06});
        ea.push_back({2'b00, 32'h20});
        ea.push_back({2'b00, 32'h22});
        add_frame(20);
        send_a(68, 20, 1'b0);
        drain_a(18);
        cmp_a("sof");
        check("sof_error_pulses", 64'(a_serr - se0), 64'(1));
        check("sof_frame_done", 64'(a_fd - fd0), 64'(1));
        add_frame(0);
        send_a(48, -1, 1'b0);
        drain_a(12);
        cmp_a("after_sof");
        check("after_sof_error", 64'(a_serr - se0), 64'(1));

        // Reset with a pixel pending mid-frame
        fd0 = a_fd;
        send_a(19, -1, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_pre_valid", a_out_valid, 1);
        @(posedge clock);
        #1;
        check("midrst_valid", a_out_valid, 0);
        check("midrst_pix", a_out_pix, 0);
        check("midrst_state", dut_a.state, S_IDLE);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        qa.delete();
        check("midrst_frame_done", 64'(a_fd - fd0), 64'(0));
        add_frame(0);
        send_a(48, -1, 1'b0);
        drain_a(12);
        cmp_a("post_rst");
        check("post_rst_frame_done", 64'(a_fd - fd0), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
